// File: rtl/i2s_pkg.sv
// Shared types and default constants for the I2S/TDM frame receiver.
package i2s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rx_state_t;

  localparam int I2S_SAMPLE_W = 16;
  localparam int I2S_SLOT_W   = 16;
  localparam int I2S_CHANNELS = 2;
  localparam int OVF_CNT_W    = 8;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchroniser for one external pin.
// With EDGE_DET set, the output is instead a registered one-clk rising-edge strobe.
module i2s_sync #(
  parameter bit EDGE_DET = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw,
  output logic synced
);

  logic meta;
  logic stable;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta   <= 1'b0;
      stable <= 1'b0;
    end else begin
      meta   <= raw;
      stable <= meta;
    end
  end

  generate
    if (EDGE_DET) begin : g_edge
      logic prev;
      logic rise;
      // Registered strobe: pin edge to strobe is three clk.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          prev <= 1'b0;
          rise <= 1'b0;
        end else begin
          prev <= stable;
          rise <= stable & ~prev;
        end
      end
      assign synced = rise;
    end else begin : g_level
      assign synced = stable;
    end
  endgenerate

endmodule

// File: rtl/i2s_frame_rx.sv
// I2S/TDM receiver: assembles CHANNELS slots into one frame behind a valid/ready holding register.
// Define I2S_RX_OVF_CNT_EN to build the saturating dropped-frame counter on ovf_count.
module i2s_frame_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = I2S_SAMPLE_W,
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int CHANNELS = I2S_CHANNELS
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         sck,
  input  logic                         ws,
  input  logic                         sd,
  output logic [CHANNELS*SAMPLE_W-1:0] frame_data,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         overflow,
  output logic                         sync_err,
  input  logic                         clear_err,
  output logic [OVF_CNT_W-1:0]         ovf_count
);

  localparam int FRAME_W = CHANNELS * SAMPLE_W;
  localparam int BIT_W   = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int SLOT_CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [BIT_W:0]   SAMPLE_LIM = (BIT_W + 1)'(SAMPLE_W);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(SLOT_W - 1);
  localparam logic [SLOT_CW-1:0] SLOT_LAST = SLOT_CW'(CHANNELS - 1);

  logic sck_rise, ws_sync, sd_sync;

  i2s_sync #(.EDGE_DET(1'b1)) u_sck (.clk(clk), .n_rst(n_rst), .raw(sck), .synced(sck_rise));
  i2s_sync #(.EDGE_DET(1'b0)) u_ws  (.clk(clk), .n_rst(n_rst), .raw(ws),  .synced(ws_sync));
  i2s_sync #(.EDGE_DET(1'b0)) u_sd  (.clk(clk), .n_rst(n_rst), .raw(sd),  .synced(sd_sync));

  rx_state_t           state, state_next;
  logic [BIT_W-1:0]    bit_cnt, bit_next;
  logic [SLOT_CW-1:0]  slot_cnt, slot_next;
  logic                ws_prev;
  logic [SAMPLE_W-1:0] shift, shift_next;
  logic [FRAME_W-1:0]  work, work_next;
  logic                shift_en, slot_wr, frame_done, sync_set, frame_drop;
  logic                frame_start, last_bit, last_slot;

  assign frame_start = sck_rise && ws_prev && !ws_sync;
  assign last_bit    = (bit_cnt == BIT_LAST);
  assign last_slot   = (slot_cnt == SLOT_LAST);

  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    slot_next  = slot_cnt;
    shift_en   = 1'b0;
    slot_wr    = 1'b0;
    frame_done = 1'b0;
    sync_set   = 1'b0;
    if (sck_rise) begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state_next = RUN;
            bit_next   = '0;
            slot_next  = '0;
          end
        end
        RUN: begin
          // A frame start on the very last bit is a legal back-to-back frame.
          if (frame_start && !(last_bit && last_slot)) begin
            sync_set  = 1'b1;
            bit_next  = '0;
            slot_next = '0;
          end else begin
            shift_en = ({1'b0, bit_cnt} < SAMPLE_LIM);
            if (last_bit) begin
              slot_wr  = 1'b1;
              bit_next = '0;
              if (last_slot) begin
                frame_done = 1'b1;
                slot_next  = '0;
                state_next = frame_start ? RUN : IDLE;
              end else begin
                slot_next = slot_cnt + 1'b1;
              end
            end else begin
              bit_next = bit_cnt + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_next = shift_en ? SAMPLE_W'({shift, sd_sync}) : shift;
    work_next  = work;
    if (slot_wr) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (slot_cnt == SLOT_CW'(k)) work_next[k*SAMPLE_W +: SAMPLE_W] = shift_next;
      end
    end
  end

  assign frame_drop = frame_done && frame_valid && !frame_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      slot_cnt <= '0;
      ws_prev  <= 1'b1;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_next;
      slot_cnt <= slot_next;
      if (sck_rise) ws_prev <= ws_sync;
    end
  end

  // Working registers carry only data and are fully rewritten every frame.
  always_ff @(posedge clk) begin
    shift <= shift_next;
    work  <= work_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (frame_done && (!frame_valid || frame_ready)) begin
        frame_data  <= work_next;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (clear_err) begin
        overflow <= 1'b0;
        sync_err <= 1'b0;
      end else begin
        if (frame_drop) overflow <= 1'b1;
        if (sync_set)   sync_err <= 1'b1;
      end
    end
  end

`ifdef I2S_RX_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_cnt <= '0;
    end else if (clear_err) begin
      ovf_cnt <= '0;
    end else if (frame_drop && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign ovf_count = ovf_cnt;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_i2s_frame_rx.sv
// Scoreboard bench for i2s_frame_rx: a stereo default instance and a 4-slot TDM instance.
module tb_i2s_frame_rx;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic clear_err = 1'b0;
  always #5 clk = ~clk;

  logic        sck_a = 1'b0, ws_a = 1'b1, sd_a = 1'b0, ready_a = 1'b1;
  logic [31:0] data_a;
  logic        valid_a, ovf_a, serr_a;
  logic [7:0]  cnt_a;

  logic        sck_b = 1'b0, ws_b = 1'b1, sd_b = 1'b0, ready_b = 1'b1;
  logic [95:0] data_b;
  logic        valid_b, ovf_b, serr_b;
  logic [7:0]  cnt_b;

  i2s_frame_rx dut_a (
    .clk(clk), .n_rst(n_rst), .sck(sck_a), .ws(ws_a), .sd(sd_a),
    .frame_data(data_a), .frame_valid(valid_a), .frame_ready(ready_a),
    .overflow(ovf_a), .sync_err(serr_a), .clear_err(clear_err), .ovf_count(cnt_a)
  );

  i2s_frame_rx #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(4)) dut_b (
    .clk(clk), .n_rst(n_rst), .sck(sck_b), .ws(ws_b), .sd(sd_b),
    .frame_data(data_b), .frame_valid(valid_b), .frame_ready(ready_b),
    .overflow(ovf_b), .sync_err(serr_b), .clear_err(clear_err), .ovf_count(cnt_b)
  );

  typedef struct {
    logic [95:0] data;
    bit          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   bus = 0;

`ifdef I2S_RX_OVF_CNT_EN
  localparam logic [7:0] OVF_EXP = 8'd1;
`else
  localparam logic [7:0] OVF_EXP = 8'd0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int which, input logic [95:0] d, input bit lat);
    exp_t e;
    e.data = d;
    e.lat  = lat;
    if (which == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // One sck period: ws/sd change with the falling edge, sampled on the rising edge.
  task automatic send_bit(input logic w, input logic d);
    if (bus == 0) begin sck_a = 1'b0; ws_a = w; sd_a = d; end
    else          begin sck_b = 1'b0; ws_b = w; sd_b = d; end
    repeat (HALF) @(negedge clk);
    if (bus == 0) sck_a = 1'b1;
    else          sck_b = 1'b1;
    rise_cyc = cyc;
    repeat (HALF) @(negedge clk);
  endtask

  // Frame start bit, then nbits data bits; slot s occupies slots[s*32 +: 32], MSB of slot first.
  task automatic send_frame(input logic [127:0] slots, input int sw, input int nbits);
    logic [127:0] t;
    int s, b;
    send_bit(1'b0, 1'b0);
    for (int j = 0; j < nbits; j++) begin
      s = j / sw;
      b = sw - 1 - (j % sw);
      t = slots >> (s * 32);
      send_bit((s == 0 && (j % sw) != sw - 1) ? 1'b0 : 1'b1, t[b]);
    end
  endtask

  function automatic logic [127:0] stereo(input logic [31:0] x);
    return {64'b0, 16'b0, x[31:16], 16'b0, x[15:0]};
  endfunction

  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL frame_a: got unexpected frame %0h, expected none", data_a);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("frame_a", {64'b0, data_a}, e.data);
        if (e.lat) check("latency_a", 96'(cyc - rise_cyc), 96'd4);
      end
    end
    if (valid_b && ready_b) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL frame_b: got unexpected frame %0h, expected none", data_b);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("frame_b", data_b, e.data);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", {64'b0, data_a}, 96'd0);
    check("rst_valid", {95'b0, valid_a}, 96'd0);
    check("rst_ovf", {95'b0, ovf_a}, 96'd0);
    check("rst_serr", {95'b0, serr_a}, 96'd0);
    check("rst_cnt", {88'b0, cnt_a}, 96'd0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // Stereo default, with latency check
    bus = 0;
    push(0, 96'hABCD1234, 1'b1);
    send_frame(stereo(32'hABCD1234), 16, 32);
    repeat (4) @(negedge clk);

    // Backpressure: second frame dropped
    ready_a = 1'b0;
    push(0, 96'h00010002, 1'b0);
    send_frame(stereo(32'h00010002), 16, 32);
    send_frame(stereo(32'h00030004), 16, 32);
    repeat (3) @(negedge clk);
    check("bp_valid", {95'b0, valid_a}, 96'd1);
    check("bp_data", {64'b0, data_a}, 96'h00010002);
    check("bp_ovf", {95'b0, ovf_a}, 96'd1);
    check("bp_cnt", {88'b0, cnt_a}, {88'b0, OVF_EXP});
    ready_a = 1'b1;
    repeat (4) @(negedge clk);

    // Short frame: restart after 10 bits of slot 1
    push(0, 96'h5555AAAA, 1'b0);
    send_frame(stereo(32'h11112222), 16, 26);
    send_frame(stereo(32'h5555AAAA), 16, 32);
    repeat (6) @(negedge clk);
    check("short_serr", {95'b0, serr_a}, 96'd1);
    check("sticky_ovf", {95'b0, ovf_a}, 96'd1);

    // Error clear
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("clr_ovf", {95'b0, ovf_a}, 96'd0);
    check("clr_serr", {95'b0, serr_a}, 96'd0);
    check("clr_cnt", {88'b0, cnt_a}, 96'd0);

    // TDM: 4 slots of 32 bits, 24 kept
    bus = 1;
    push(1, 96'h345678_DEF012_789ABC_123456, 1'b0);
    send_frame({32'h34567801, 32'hDEF012EF, 32'h789ABCCD, 32'h123456AB}, 32, 128);
    repeat (6) @(negedge clk);

    // Reset mid-frame
    bus = 0;
    send_frame(stereo(32'hDEADBEEF), 16, 5);
    n_rst = 1'b0;
    repeat (3) send_bit(1'b0, 1'b1);
    check("mid_rst_data", {64'b0, data_a}, 96'd0);
    check("mid_rst_valid", {95'b0, valid_a}, 96'd0);
    check("mid_rst_ovf", {95'b0, ovf_a}, 96'd0);
    check("mid_rst_serr", {95'b0, serr_a}, 96'd0);
    check("mid_rst_cnt", {88'b0, cnt_a}, 96'd0);
    sck_a = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    push(0, 96'h0F0FF0F0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_frame(stereo(32'h0F0FF0F0), 16, 32);
    repeat (20) @(negedge clk);
    check("post_rst_serr", {95'b0, serr_a}, 96'd0);
    check("qa_empty", 96'(qa.size()), 96'd0);
    check("qb_empty", 96'(qb.size()), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
